// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU operation scheduler.
// State encoding, opcodes and the queued command layout.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef struct packed {
    logic [1:0] ctrl;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] dest;
  } sched_cmd_t;

endpackage

// File: rtl/sched_fifo.sv
// Generic synchronous FIFO with occupancy count.
// Pointers wrap naturally since DEPTH is a power of two.
module sched_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  // A full FIFO refuses pushes even when a pop frees a slot this cycle
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Queues ALU commands and runs them one at a time through a
// start/done ALU, writing results to the register memory.
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_ctrl,
  input  logic [1:0]             in_a,
  input  logic [1:0]             in_b,
  input  logic [1:0]             in_dest,
  output logic                   alu_start,
  output logic [1:0]             alu_a,
  output logic [1:0]             alu_b,
  output logic [1:0]             alu_ctrl,
  input  logic                   alu_done,
  input  logic [3:0]             alu_y,
  input  logic                   alu_c,
  output logic                   rf_we,
  output logic [1:0]             rf_addr,
  output logic [3:0]             rf_wdata,
  output logic                   cmp_valid,
  output logic                   cmp_carry,
  output logic                   cmp_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] pending
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_e     state_q;
  sched_cmd_t in_cmd;
  sched_cmd_t head;
  logic       full;
  logic       empty;
  logic       pop;
  logic [1:0] dest_q;
  logic [7:0] tmr_q;
  logic [7:0] tmr_nxt;

  assign in_cmd  = '{ctrl: in_ctrl, a: in_a, b: in_b, dest: in_dest};
  assign in_ready = ~full;
  assign pop     = (state_q == S_IDLE) & ~empty;
  assign busy    = (state_q != S_IDLE);
  assign tmr_nxt = tmr_q + 8'd1;

  sched_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(sched_cmd_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (in_valid),
    .pop_i   (pop),
    .wdata_i (in_cmd),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (pending)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      alu_start <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= '0;
      dest_q    <= '0;
      tmr_q     <= '0;
      rf_we     <= 1'b0;
      rf_addr   <= '0;
      rf_wdata  <= '0;
      cmp_valid <= 1'b0;
      cmp_carry <= 1'b0;
      cmp_err   <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      rf_we     <= 1'b0;
      cmp_valid <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (!empty) begin
            alu_ctrl  <= head.ctrl;
            alu_a     <= head.a;
            alu_b     <= head.b;
            dest_q    <= head.dest;
            alu_start <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmr_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // done takes priority over a timeout in the same cycle
          if (alu_done) begin
            rf_wdata  <= alu_y;
            rf_addr   <= dest_q;
            rf_we     <= 1'b1;
            cmp_valid <= 1'b1;
            cmp_carry <= alu_c;
            cmp_err   <= 1'b0;
            state_q   <= S_WRITE;
          end else begin
            tmr_q <= tmr_nxt;
            if (tmr_nxt == TO) begin
              cmp_valid <= 1'b1;
              cmp_carry <= 1'b0;
              cmp_err   <= 1'b1;
              state_q   <= S_IDLE;
            end
          end
        end
        S_WRITE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
